// File: rtl/generador_perfil_pasos_if.sv
// Move request and step-clock signals between the motion controller and the step-rate generator.
interface generador_perfil_pasos_if #(
  parameter int unsigned CNT_W = 16
);
  logic             inicio;
  logic [CNT_W-1:0] pasosObjetivo;
  logic             direccion;
  logic             paro;
  logic             frecuencia;
  logic             direccionGiro;
  logic             ocupado;
  logic             terminado;
  logic [CNT_W-1:0] pasosRestantes;

  modport master (
    output inicio, pasosObjetivo, direccion, paro,
    input  frecuencia, direccionGiro, ocupado, terminado, pasosRestantes
  );

  modport slave (
    input  inicio, pasosObjetivo, direccion, paro,
    output frecuencia, direccionGiro, ocupado, terminado, pasosRestantes
  );
endinterface

// File: rtl/generador_perfil_pasos.sv
// Trapezoidal step-rate generator: counted burst of step edges with a linear-period
// acceleration ramp, cruise at MIN_DIV and a mirrored deceleration ramp.
module generador_perfil_pasos #(
  parameter int unsigned START_DIV = 250000,
  parameter int unsigned MIN_DIV   = 100000,
  parameter int unsigned ACCEL_DEC = 5000,
  parameter int unsigned DIV_W     = 20,
  parameter int unsigned CNT_W     = 16
) (
  input logic                     clk,
  input logic                     rst,
  generador_perfil_pasos_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ACCEL, CRUISE, DECEL, DONE} estado_t;

  localparam logic [DIV_W-1:0] START_P = DIV_W'(START_DIV);
  localparam logic [DIV_W-1:0] MIN_P   = DIV_W'(MIN_DIV);
  localparam logic [DIV_W-1:0] ACC_P   = DIV_W'(ACCEL_DEC);

  estado_t          estado_q, estado_d;
  logic [DIV_W-1:0] periodo_q, periodo_d;
  logic [DIV_W-1:0] contador_q, contador_d;
  logic [CNT_W-1:0] rampa_q, rampa_d;
  logic [CNT_W-1:0] restantes_q, restantes_d;
  logic             paro_q, paro_d;
  logic             dir_q, dir_d;
  logic             frecuencia_q, frecuencia_d;
  logic             ocupado_q, ocupado_d;
  logic             terminado_q, terminado_d;

  logic [DIV_W-1:0] perUp, perDown;
  logic [CNT_W-1:0] remMenos, rampaMin;
  logic             activo_d;

  // Saturating period steps; the period never leaves [MIN_P, START_P] so neither subtraction underflows.
  always_comb begin
    perUp    = ((START_P - periodo_q) <= ACC_P) ? START_P : (periodo_q + ACC_P);
    perDown  = ((periodo_q - MIN_P) <= ACC_P) ? MIN_P : (periodo_q - ACC_P);
    remMenos = restantes_q - CNT_W'(1);
    rampaMin = (remMenos < rampa_q) ? remMenos : rampa_q;
  end

  always_comb begin
    estado_d    = estado_q;
    periodo_d   = periodo_q;
    contador_d  = contador_q;
    rampa_d     = rampa_q;
    restantes_d = restantes_q;
    paro_d      = paro_q;
    dir_d       = dir_q;
    terminado_d = 1'b0;

    case (estado_q)
      IDLE: begin
        if (bus.inicio) begin
          if (bus.pasosObjetivo != '0) begin
            restantes_d = bus.pasosObjetivo;
            dir_d       = bus.direccion;
            periodo_d   = START_P;
            rampa_d     = '0;
            contador_d  = '0;
            estado_d    = ACCEL;
          end else begin
            estado_d    = DONE;
            terminado_d = 1'b1;
          end
        end
      end

      ACCEL, CRUISE, DECEL: begin
        if (estado_q != DECEL && bus.paro) begin
          paro_d = 1'b1;
        end
        if (contador_q == periodo_q - DIV_W'(1)) begin
          contador_d  = '0;
          restantes_d = remMenos;
          if (remMenos == '0) begin
            estado_d    = DONE;
            terminado_d = 1'b1;
          end else if (estado_q != DECEL && (paro_q || remMenos <= rampa_q)) begin
            // Decelerate over as many steps as were spent accelerating.
            restantes_d = rampaMin;
            if (rampaMin == '0) begin
              estado_d    = DONE;
              terminado_d = 1'b1;
            end else begin
              estado_d  = DECEL;
              periodo_d = perUp;
            end
          end else if (estado_q == ACCEL) begin
            periodo_d = perDown;
            rampa_d   = rampa_q + CNT_W'(1);
            if (perDown == MIN_P) begin
              estado_d = CRUISE;
            end
          end else if (estado_q == DECEL) begin
            periodo_d = perUp;
          end
        end else begin
          contador_d = contador_q + DIV_W'(1);
        end
      end

      DONE: begin
        estado_d = IDLE;
        paro_d   = 1'b0;
      end

      default: estado_d = IDLE;
    endcase

    activo_d     = (estado_d == ACCEL) || (estado_d == CRUISE) || (estado_d == DECEL);
    ocupado_d    = activo_d;
    frecuencia_d = activo_d && (contador_d < (periodo_d >> 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q     <= IDLE;
      periodo_q    <= START_P;
      contador_q   <= '0;
      rampa_q      <= '0;
      restantes_q  <= '0;
      paro_q       <= 1'b0;
      dir_q        <= 1'b0;
      frecuencia_q <= 1'b0;
      ocupado_q    <= 1'b0;
      terminado_q  <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      periodo_q    <= periodo_d;
      contador_q   <= contador_d;
      rampa_q      <= rampa_d;
      restantes_q  <= restantes_d;
      paro_q       <= paro_d;
      dir_q        <= dir_d;
      frecuencia_q <= frecuencia_d;
      ocupado_q    <= ocupado_d;
      terminado_q  <= terminado_d;
    end
  end

  assign bus.frecuencia     = frecuencia_q;
  assign bus.direccionGiro  = dir_q;
  assign bus.ocupado        = ocupado_q;
  assign bus.terminado      = terminado_q;
  assign bus.pasosRestantes = restantes_q;

endmodule

// File: tb/tb_generador_perfil_pasos.sv
// Scoreboard bench: expected step periods are queued per move and popped as each step
// (rising edge to rising edge, or last edge to terminado) is observed.
module tb_generador_perfil_pasos;

  logic clk = 1'b0;
  logic rst = 1'b0;

  generador_perfil_pasos_if #(.CNT_W(16)) bus ();

  generador_perfil_pasos #(
    .START_DIV(20), .MIN_DIV(8), .ACCEL_DEC(4), .DIV_W(20), .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int numChecks = 0;
  int numFails  = 0;
  int expQ[$];
  bit expDir = 1'b0;

  int cycle = 0;
  int edgeCount = 0;
  int terminadoCount = 0;
  int lastEvent = 0;
  int firstEdge = 0;
  int lastTotal = 0;
  bit haveLast = 1'b0;
  bit prevFrec = 1'b0;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    numChecks++;
    if (observed != expected) begin
      numFails++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Step-interval monitor, sampling on the falling edge.
  always @(negedge clk) begin
    cycle++;
    if (rst) begin
      haveLast = 1'b0;
      prevFrec = 1'b0;
    end else begin
      if ((bus.frecuencia && !prevFrec) || bus.terminado) begin
        if (haveLast) begin
          if (expQ.size() == 0) checkOutput("colaVaciaAlMedir", 0, cycle - lastEvent);
          else checkOutput("periodo", cycle - lastEvent, expQ.pop_front());
        end
        if (bus.terminado) begin
          terminadoCount++;
          if (haveLast) lastTotal = cycle - firstEdge;
          haveLast = 1'b0;
        end else begin
          if (!haveLast) firstEdge = cycle;
          edgeCount++;
          haveLast  = 1'b1;
          lastEvent = cycle;
          checkOutput("direccionGiro", int'(bus.direccionGiro), int'(expDir));
          checkOutput("ocupadoEnPaso", int'(bus.ocupado), 1);
        end
      end
      prevFrec = bus.frecuencia;
    end
  end

  task automatic applyStimulus(input logic [15:0] n, input bit dir);
    @(negedge clk);
    bus.inicio        = 1'b1;
    bus.pasosObjetivo = n;
    bus.direccion     = dir;
    @(negedge clk);
    bus.inicio        = 1'b0;
    bus.pasosObjetivo = 16'd0;
    bus.direccion     = 1'b0;
  endtask

  task automatic waitTerminado(input int prev, input int budget);
    int n = 0;
    while (terminadoCount == prev && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("terminadoLlego", terminadoCount - prev, 1);
  endtask

  task automatic waitEdges(input int target, input int budget);
    int n = 0;
    while (edgeCount < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("esperaFlancos", int'(edgeCount >= target), 1);
  endtask

  task automatic runMove(input logic [15:0] n, input bit dir, input int periods[$], input int total);
    int e0, t0;
    e0 = edgeCount;
    t0 = terminadoCount;
    foreach (periods[i]) expQ.push_back(periods[i]);
    expDir = dir;
    applyStimulus(n, dir);
    checkOutput("ocupadoTrasInicio", int'(bus.ocupado), 1);
    checkOutput("restantesTrasInicio", int'(bus.pasosRestantes), int'(n));
    waitTerminado(t0, 400);
    repeat (5) @(negedge clk);
    checkOutput("flancos", edgeCount - e0, periods.size());
    checkOutput("terminadoUnaVez", terminadoCount - t0, 1);
    checkOutput("total", lastTotal, total);
    checkOutput("restantesFinal", int'(bus.pasosRestantes), 0);
    checkOutput("ocupadoFinal", int'(bus.ocupado), 0);
    checkOutput("colaVacia", expQ.size(), 0);
  endtask

  initial begin
    int e0, t0;
    int full[$]  = '{20, 16, 12, 8, 8, 8, 8, 12, 16, 20};
    int corto[$] = '{20, 16, 12, 16};
    int stop[$]  = '{20, 16, 12, 8, 8, 12, 16, 20};

    bus.inicio = 1'b0;
    bus.pasosObjetivo = 16'd0;
    bus.direccion = 1'b0;
    bus.paro = 1'b0;

    $display("[TB] reset and idle");
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("rstFrecuencia", int'(bus.frecuencia), 0);
    checkOutput("rstDireccion", int'(bus.direccionGiro), 0);
    checkOutput("rstOcupado", int'(bus.ocupado), 0);
    checkOutput("rstTerminado", int'(bus.terminado), 0);
    checkOutput("rstRestantes", int'(bus.pasosRestantes), 0);
    e0 = edgeCount;
    repeat (200) @(negedge clk);
    checkOutput("idleSinFlancos", edgeCount - e0, 0);

    $display("[TB] full trapezoid");
    runMove(16'd10, 1'b1, full, 128);

    $display("[TB] short move");
    runMove(16'd4, 1'b0, corto, 64);

    $display("[TB] controlled stop");
    fork
      runMove(16'd100, 1'b1, stop, 112);
      begin
        e0 = edgeCount;
        waitEdges(e0 + 2, 200);
        @(negedge clk);
        bus.inicio = 1'b1;
        bus.pasosObjetivo = 16'd3;
        bus.direccion = 1'b0;
        @(negedge clk);
        bus.inicio = 1'b0;
        bus.pasosObjetivo = 16'd0;
        waitEdges(e0 + 5, 200);
        repeat (2) @(negedge clk);
        bus.paro = 1'b1;
        @(negedge clk);
        bus.paro = 1'b0;
      end
    join

    $display("[TB] zero count");
    e0 = edgeCount;
    t0 = terminadoCount;
    applyStimulus(16'd0, 1'b0);
    checkOutput("ceroTerminado", int'(bus.terminado), 1);
    checkOutput("ceroOcupado", int'(bus.ocupado), 0);
    @(negedge clk);
    checkOutput("ceroTerminadoPulso", int'(bus.terminado), 0);
    checkOutput("ceroOcupadoDespues", int'(bus.ocupado), 0);
    repeat (50) @(negedge clk);
    checkOutput("ceroSinFlancos", edgeCount - e0, 0);
    checkOutput("ceroTerminadoCuenta", terminadoCount - t0, 1);

    $display("[TB] async reset mid-move");
    e0 = edgeCount;
    foreach (full[i]) expQ.push_back(full[i]);
    expDir = 1'b1;
    applyStimulus(16'd10, 1'b1);
    waitEdges(e0 + 5, 200);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("asyncFrecuencia", int'(bus.frecuencia), 0);
    checkOutput("asyncOcupado", int'(bus.ocupado), 0);
    checkOutput("asyncRestantes", int'(bus.pasosRestantes), 0);
    @(negedge clk);
    #1 rst = 1'b0;
    expQ.delete();
    e0 = edgeCount;
    repeat (30) @(negedge clk);
    checkOutput("asyncSinFlancos", edgeCount - e0, 0);
    runMove(16'd10, 1'b1, full, 128);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numChecks, numFails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/generador_perfil_pasos.md
Name: generador_perfil_pasos

Overview:
- Step-rate generator that sits directly upstream of the unipolar stepper phase sequencer.
- Its outputs `frecuencia` and `direccionGiro` drive the sequencer's step clock and direction inputs.
- Produces a counted burst of step edges with a linear-period acceleration ramp, cruise at maximum rate, and a mirrored deceleration ramp.
- Lets the 28BYJ-48 start and stop at high torque without missing steps; replaces the fixed clock divider on the step path.

Parameters:
- START_DIV, 250000: step period in clk cycles at start/stop (200 Hz at 50 MHz).
- MIN_DIV, 100000: cruise step period in clk cycles; must be < START_DIV.
- ACCEL_DEC, 5000: period change in clk cycles applied per step while ramping.
- DIV_W, 20: width of the period and cycle counters; must hold START_DIV.
- CNT_W, 16: width of the step counters.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous reset, active-high.
- inicio, input, 1: start request; sampled only in IDLE.
- pasosObjetivo, input, CNT_W: number of steps to execute; latched on an accepted inicio.
- direccion, input, 1: requested direction; latched on an accepted inicio.
- paro, input, 1: controlled-stop request; sampled in ACCEL or CRUISE.
- frecuencia, output, 1: step clock to the sequencer; each rising edge is one step.
- direccionGiro, output, 1: latched direction; constant for the whole move.
- ocupado, output, 1: high from accepted inicio until the move ends.
- terminado, output, 1: one-cycle pulse when a move ends.
- pasosRestantes, output, CNT_W: steps not yet completed.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - frecuencia, direccionGiro, ocupado and terminado are 0; pasosRestantes is 0.
  - Period register = START_DIV, rampSteps = 0, cycle counter = 0, stop flag cleared.
  - Reset mid-move drops frecuencia immediately; no further edges until a new inicio.
- States: IDLE, ACCEL, CRUISE, DECEL, DONE.
- IDLE:
  - inicio=1 with pasosObjetivo≠0: latch count into pasosRestantes, direccion into direccionGiro, period = START_DIV, rampSteps = 0, counter = 0; go to ACCEL and set ocupado=1.
  - inicio=1 with pasosObjetivo=0: go to DONE; no frecuencia edge.
  - paro is ignored.
- Step timing (ACCEL, CRUISE, DECEL):
  - The counter runs 0..period-1 each step.
  - frecuencia = 1 while counter < (period>>1), otherwise 0.
  - The first rising edge occurs in the first cycle after inicio is accepted.
- Step end (counter = period-1), with rem' = pasosRestantes-1:
  - Load pasosRestantes = rem' and reset counter to 0.
  - If rem' = 0: go to DONE.
  - Else if the stop flag is set, or rem' ≤ rampSteps (ACCEL/CRUISE only):
    - pasosRestantes = min(rem', rampSteps); if that is 0, go to DONE.
    - Otherwise go to DECEL and set period = min(period+ACCEL_DEC, START_DIV).
  - Else in ACCEL:
    - period = max(period-ACCEL_DEC, MIN_DIV) and rampSteps++.
    - If the new period = MIN_DIV, go to CRUISE.
  - Else in CRUISE: period is unchanged.
  - Else in DECEL: period = min(period+ACCEL_DEC, START_DIV).
- paro: a high sample in ACCEL or CRUISE sets the stop flag. It takes effect at the next step end; the current step always completes.
- DONE:
  - Lasts one cycle: terminado=1, ocupado=0, frecuencia=0, stop flag cleared; then IDLE.
  - direccionGiro holds its value until the next accepted inicio.
- inicio while ocupado=1 is ignored.
- The counter never wraps; all period arithmetic saturates as stated above.

Test Plan (bench parameters START_DIV=20, MIN_DIV=8, ACCEL_DEC=4):
- Reset then idle: rst pulse, no inicio → all outputs 0; no frecuencia edge for 200 cycles.
- Full trapezoid, inicio with pasosObjetivo=10, direccion=1:
  - Exactly 10 rising edges on frecuencia.
  - Step periods 20,16,12,8,8,8,8,12,16,20; total 128 cycles.
  - direccionGiro=1 throughout; terminado pulses once; pasosRestantes reads 0.
- Short move, pasosObjetivo=4 → periods 20,16,12,16; then terminado; total 64 cycles.
- Controlled stop, pasosObjetivo=100, paro pulsed during the 5th step:
  - Periods 20,16,12,8,8,12,16,20; 8 edges total, then terminado.
  - Re-issuing inicio during the move has no effect.
- Zero count, pasosObjetivo=0 → no frecuencia edge; terminado=1 one cycle later; ocupado stays 0.
- Async reset mid-move, rst asserted during CRUISE off the clock edge → frecuencia, ocupado and pasosRestantes clear immediately; a fresh move then behaves as in the full-trapezoid test.
